// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// ALUOp / ALUSrcB / PCSource codes and the control-vector payload.
package mips_mc_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = STATE_W'(0),
        S_DECODE    = STATE_W'(1),
        S_MEM_ADDR  = STATE_W'(2),
        S_MEM_READ  = STATE_W'(3),
        S_MEM_WB    = STATE_W'(4),
        S_MEM_WRITE = STATE_W'(5),
        S_R_EXEC    = STATE_W'(6),
        S_R_WB      = STATE_W'(7),
        S_BRANCH    = STATE_W'(8),
        S_JUMP      = STATE_W'(9),
        S_I_EXEC    = STATE_W'(10),
        S_I_WB      = STATE_W'(11)
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       shamt_sel;
        logic       illegal_op;
    } ctrl_t;

    // States whose exit completes (retires) an instruction
    function automatic logic is_final(state_e s);
        case (s)
            S_R_WB, S_I_WB, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP: return 1'b1;
            default:                                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control <-> datapath signal bundle: IR fields and flags in, enables and selects out.
interface mips_multicycle_control_if #(parameter int unsigned CNT_W = 32);

    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic [1:0]       pc_source;
    logic             shamt_sel;
    logic             illegal_op;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        input  op, funct, zero, mem_ready,
        output pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               shamt_sel, illegal_op, retired_cnt
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
               reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               shamt_sel, illegal_op, retired_cnt
    );

endinterface

// File: rtl/mips_mc_output_decode.sv
// Moore output decode: current state (plus IR op/funct and ALU zero) -> control vector.
// Unused state encodings decode to an all-zero vector.
module mips_mc_output_decode
    import mips_mc_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ok_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = mem_ok_i;
                ctrl_o.pc_write  = mem_ok_i;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH;
                ctrl_o.alu_op    = ALUOP_ADD;
                case (op_i)
                    OP_RTYPE, OP_ADDI, OP_ORI, OP_LW, OP_SW,
                    OP_BEQ, OP_BNE, OP_J: ctrl_o.illegal_op = 1'b0;
                    default:              ctrl_o.illegal_op = 1'b1;
                endcase
            end
            S_R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALUOP_FUNCT;
                ctrl_o.shamt_sel = (funct_i == FUNCT_SLL) || (funct_i == FUNCT_SRL);
            end
            S_R_WB: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            S_I_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = (op_i == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
            end
            S_I_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl_o.i_or_d   = 1'b1;
                ctrl_o.mem_read = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.i_or_d    = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            // beq/bne resolved here so the PC only loads on a taken branch
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.pc_source = PCSRC_ALUOUT;
                ctrl_o.pc_write  = ((op_i == OP_BEQ) &&  zero_i) ||
                                   ((op_i == OP_BNE) && !zero_i);
            end
            S_JUMP: begin
                ctrl_o.pc_source = PCSRC_JUMP;
                ctrl_o.pc_write  = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: state register, dispatch, memory-wait hold and retired counter.
// Optional MC_MEM_WAIT_EN: FETCH/MEM_READ/MEM_WRITE hold while mem_ready is low.
module mips_multicycle_control
    import mips_mc_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    mips_multicycle_control_if.master  bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_ok;
    ctrl_t            ctrl;

`ifdef MC_MEM_WAIT_EN
    assign mem_ok = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign mem_ok           = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_FETCH:     state_d = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_RTYPE:        state_d = S_R_EXEC;
                    OP_ADDI, OP_ORI: state_d = S_I_EXEC;
                    OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    default:         state_d = S_FETCH;
                endcase
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            S_MEM_ADDR:  state_d = (bus.op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = mem_ok ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ok ? S_FETCH : S_MEM_WRITE;
            S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
        // Count on exit from a completing state; wraps freely
        if (is_final(state_q) && (state_d != state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    mips_mc_output_decode u_decode (
        .state_i  (state_q),
        .op_i     (bus.op),
        .funct_i  (bus.funct),
        .zero_i   (bus.zero),
        .mem_ok_i (mem_ok),
        .ctrl_o   (ctrl)
    );

    // Strobes are forced low for the whole time reset is asserted
    assign bus.pc_write    = ctrl.pc_write  & reset;
    assign bus.ir_write    = ctrl.ir_write  & reset;
    assign bus.mem_read    = ctrl.mem_read  & reset;
    assign bus.mem_write   = ctrl.mem_write & reset;
    assign bus.reg_write   = ctrl.reg_write & reset;
    assign bus.i_or_d      = ctrl.i_or_d;
    assign bus.mem_to_reg  = ctrl.mem_to_reg;
    assign bus.reg_dst     = ctrl.reg_dst;
    assign bus.alu_src_a   = ctrl.alu_src_a;
    assign bus.alu_src_b   = ctrl.alu_src_b;
    assign bus.alu_op      = ctrl.alu_op;
    assign bus.pc_source   = ctrl.pc_source;
    assign bus.shamt_sel   = ctrl.shamt_sel;
    assign bus.illegal_op  = ctrl.illegal_op;
    assign bus.retired_cnt = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: instruction table plus reset corner cases.
module tb_mips_multicycle_control;

    localparam int unsigned CNT_W = 4;

    typedef enum int {P_F, P_D, P_RE, P_RW, P_IE, P_IW, P_MA, P_MR, P_MWR, P_MWB, P_BR, P_J} phase_e;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         ncyc;
        phase_e     ph [5];
        bit         retire;
    } vec_t;

    typedef struct {
        string            tag;
        logic [17:0]      ctrl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_multicycle_control_if #(.CNT_W(CNT_W)) bus ();

    mips_multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t             sb [$];
    vec_t             tbl [15];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_cnt;

    function automatic vec_t mk(string n, logic [5:0] op, logic [5:0] funct, logic z, int nc,
                                phase_e p0, phase_e p1, phase_e p2, phase_e p3, phase_e p4, bit r);
        vec_t v;
        v.name = n; v.op = op; v.funct = funct; v.zero = z; v.ncyc = nc; v.retire = r;
        v.ph[0] = p0; v.ph[1] = p1; v.ph[2] = p2; v.ph[3] = p3; v.ph[4] = p4;
        return v;
    endfunction

    // Expected control vector for one phase, written from the state table
    function automatic logic [17:0] exp_vec(phase_e ph, logic [5:0] op, logic [5:0] funct, logic z);
        logic pw, iod, mr, mw, irw, m2r, rd, rw, sa, ss, ill;
        logic [1:0] sbs, ps;
        logic [2:0] ao;
        {pw, iod, mr, mw, irw, m2r, rd, rw, sa, ss, ill} = '0;
        sbs = 2'd0; ps = 2'd0; ao = 3'd0;
        case (ph)
            P_F:   begin mr = 1'b1; irw = 1'b1; sbs = 2'd1; pw = 1'b1; end
            P_D:   begin sbs = 2'd3;
                         ill = !(op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B}); end
            P_RE:  begin sa = 1'b1; ao = 3'b010; ss = (funct == 6'h00) || (funct == 6'h02); end
            P_RW:  begin rd = 1'b1; rw = 1'b1; end
            P_IE:  begin sa = 1'b1; sbs = 2'd2; ao = (op == 6'h0D) ? 3'b011 : 3'b000; end
            P_IW:  rw = 1'b1;
            P_MA:  begin sa = 1'b1; sbs = 2'd2; end
            P_MR:  begin iod = 1'b1; mr = 1'b1; end
            P_MWR: begin iod = 1'b1; mw = 1'b1; end
            P_MWB: begin m2r = 1'b1; rw = 1'b1; end
            P_BR:  begin sa = 1'b1; ao = 3'b001; ps = 2'd1;
                         pw = ((op == 6'h04) && z) || ((op == 6'h05) && !z); end
            P_J:   begin ps = 2'd2; pw = 1'b1; end
            default: ;
        endcase
        return {pw, iod, mr, mw, irw, m2r, rd, rw, sa, sbs, ao, ps, ss, ill};
    endfunction

    function automatic logic [17:0] dut_vec();
        return {bus.pc_write, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.pc_source, bus.shamt_sel, bus.illegal_op};
    endfunction

    task automatic check_pop();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
            return;
        end
        e = sb.pop_front();
        if (dut_vec() !== e.ctrl || bus.retired_cnt !== e.cnt) begin
            errors++;
            $display("FAIL %s: got ctrl=%05h cnt=%0d, expected ctrl=%05h cnt=%0d",
                     e.tag, dut_vec(), bus.retired_cnt, e.ctrl, e.cnt);
        end
    endtask

    task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_ready();
`ifdef MC_MEM_WAIT_EN
        bus.mem_ready = 1'b1;
`else
        bus.mem_ready = 1'($urandom_range(0, 1));
`endif
    endtask

    // Called just after a rising edge with the DUT in FETCH
    task automatic run_vec(vec_t v, string pass);
        for (int c = 0; c < v.ncyc; c++) begin
            bus.op = v.op; bus.funct = v.funct; bus.zero = v.zero;
            drive_ready();
            sb.push_back('{$sformatf("%s/%s/c%0d", pass, v.name, c),
                           exp_vec(v.ph[c], v.op, v.funct, v.zero), exp_cnt});
            @(negedge clk);
            check_pop();
            @(posedge clk);
            #1;
        end
        if (v.retire) exp_cnt = exp_cnt + CNT_W'(1);
    endtask

    task automatic check_strobes_low(string name);
        check_val({name, "_strobes"},
                  32'({bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write}), 32'd0);
        check_val({name, "_cnt"}, 32'(bus.retired_cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk("add",    6'h00, 6'h20, 1'b1, 4, P_F, P_D, P_RE, P_RW, P_F, 1'b1);
        tbl[1]  = mk("lw",     6'h23, 6'h05, 1'b0, 5, P_F, P_D, P_MA, P_MR, P_MWB, 1'b1);
        tbl[2]  = mk("sw",     6'h2B, 6'h00, 1'b1, 4, P_F, P_D, P_MA, P_MWR, P_F, 1'b1);
        tbl[3]  = mk("beq_z1", 6'h04, 6'h00, 1'b1, 3, P_F, P_D, P_BR, P_F, P_F, 1'b1);
        tbl[4]  = mk("beq_z0", 6'h04, 6'h00, 1'b0, 3, P_F, P_D, P_BR, P_F, P_F, 1'b1);
        tbl[5]  = mk("bne_z1", 6'h05, 6'h00, 1'b1, 3, P_F, P_D, P_BR, P_F, P_F, 1'b1);
        tbl[6]  = mk("bne_z0", 6'h05, 6'h00, 1'b0, 3, P_F, P_D, P_BR, P_F, P_F, 1'b1);
        tbl[7]  = mk("ill_3f", 6'h3F, 6'h00, 1'b0, 2, P_F, P_D, P_F, P_F, P_F, 1'b0);
        tbl[8]  = mk("addi",   6'h08, 6'h3F, 1'b0, 4, P_F, P_D, P_IE, P_IW, P_F, 1'b1);
        tbl[9]  = mk("ori",    6'h0D, 6'h00, 1'b1, 4, P_F, P_D, P_IE, P_IW, P_F, 1'b1);
        tbl[10] = mk("sll",    6'h00, 6'h00, 1'b0, 4, P_F, P_D, P_RE, P_RW, P_F, 1'b1);
        tbl[11] = mk("srl",    6'h00, 6'h02, 1'b0, 4, P_F, P_D, P_RE, P_RW, P_F, 1'b1);
        tbl[12] = mk("j",      6'h02, 6'h00, 1'b0, 3, P_F, P_D, P_J, P_F, P_F, 1'b1);
        tbl[13] = mk("ill_01", 6'h01, 6'h00, 1'b1, 2, P_F, P_D, P_F, P_F, P_F, 1'b0);
        tbl[14] = mk("sub",    6'h00, 6'h22, 1'b0, 4, P_F, P_D, P_RE, P_RW, P_F, 1'b1);

        reset = 1'b0;
        bus.op = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        exp_cnt = '0;

        repeat (2) @(posedge clk);
        #1;
        check_strobes_low("in_reset");
        reset = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i], "p0");

        // Abort an add while it sits in DECODE
        bus.op = 6'h00; bus.funct = 6'h20; bus.zero = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_strobes_low("mid_decode_reset");
        @(posedge clk);
        #1 check_strobes_low("held_reset");
        reset = 1'b1;
        exp_cnt = '0;

        // Two passes retire 26 instructions, wrapping the 4-bit counter
        foreach (tbl[i]) run_vec(tbl[i], "p1");
        foreach (tbl[i]) run_vec(tbl[i], "p2");

        @(negedge clk);
        check_val("final_cnt_wrap", 32'(bus.retired_cnt), 32'(exp_cnt));
        check_val("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
